// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus requesters and rr_bus_arbiter.
// The master modport is the arbiter side; slave is the requester side.
interface rr_bus_arbiter_if #(
   parameter int N_CH = 4,
   parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [N_CH-1:0] req;
   logic [N_CH-1:0] done;
   logic [N_CH-1:0] gnt;
   logic [ID_W-1:0] gnt_id;
   logic            bus_bsy;
   logic            to_pulse;
   logic [ID_W-1:0] to_id;

   modport master (
      input  req, done,
      output gnt, gnt_id, bus_bsy, to_pulse, to_id
   );

   modport slave (
      output req, done,
      input  gnt, gnt_id, bus_bsy, to_pulse, to_id
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and a dead TURN cycle after every release.
// Define RR_ARB_WATCHDOG_EN to compile in the HOLD_MAX hold-time watchdog.
module rr_bus_arbiter #(
   parameter int N_CH     = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   rr_bus_arbiter_if.master  bus
);
   localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] nxt_ptr;
   logic [ID_W-1:0] win_id;
   logic [N_CH-1:0] win_oh;
   logic            win_vld;
   logic            norm_rel;
   logic            force_rel;
   logic            expire;

   // Rotating search: walking k downward leaves the lowest offset from ptr as the winner.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_id  = '0;
      win_oh  = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (bus.req[idx]) begin
            win_vld = 1'b1;
            win_id  = idx[ID_W-1:0];
            win_oh  = '0;
            win_oh[idx] = 1'b1;
         end
      end
   end

   assign norm_rel  = bus.done[bus.gnt_id] || !bus.req[bus.gnt_id];
   assign force_rel = !norm_rel && expire;
   assign nxt_ptr   = (bus.gnt_id == ID_W'(N_CH - 1)) ? '0 : bus.gnt_id + ID_W'(1);

`ifdef RR_ARB_WATCHDOG_EN
   localparam int HC_W = $clog2(HOLD_MAX + 1);

   logic [HC_W-1:0] hold_cnt;

   // Count reads HOLD_MAX-1 at the edge that closes the HOLD_MAX-th grant cycle.
   assign expire = (hold_cnt >= HC_W'(HOLD_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt     <= '0;
         bus.to_pulse <= 1'b0;
         bus.to_id    <= '0;
      end else begin
         bus.to_pulse <= 1'b0;
         if (state != BUSY) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HC_W'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HC_W'(1);
         end
         if (state == BUSY && force_rel) begin
            bus.to_pulse <= 1'b1;
            bus.to_id    <= bus.gnt_id;
         end
      end
   end
`else
   assign expire       = 1'b0;
   assign bus.to_pulse = 1'b0;
   assign bus.to_id    = '0;
`endif

   // NOTE: state and outputs are flops, so every assignment here is non-blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         bus.gnt     <= '0;
         bus.gnt_id  <= '0;
         bus.bus_bsy <= 1'b0;
      end else begin
         case (state)
            IDLE, TURN: begin
               if (win_vld) begin
                  state       <= BUSY;
                  bus.gnt     <= win_oh;
                  bus.gnt_id  <= win_id;
                  bus.bus_bsy <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (norm_rel || force_rel) begin
                  state       <= TURN;
                  ptr         <= nxt_ptr;
                  bus.gnt     <= '0;
                  bus.gnt_id  <= '0;
                  bus.bus_bsy <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               bus.gnt     <= '0;
               bus.gnt_id  <= '0;
               bus.bus_bsy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized bench for rr_bus_arbiter: a 4-channel and a 3-channel instance checked against
// a cycle-level ownership model; watchdog scenarios are built when RR_ARB_WATCHDOG_EN is defined.
module tb_rr_bus_arbiter;
   localparam int HOLD_MAX = 16;

   typedef struct {
      int own;
      int ptr;
      int held;
      bit to;
      int toid;
   } model_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   model_t m4;
   model_t m3;

   rr_bus_arbiter_if #(.N_CH(4)) bus4 ();
   rr_bus_arbiter_if #(.N_CH(3)) bus3 ();

   rr_bus_arbiter #(.N_CH(4), .HOLD_MAX(HOLD_MAX)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   rr_bus_arbiter #(.N_CH(3), .HOLD_MAX(HOLD_MAX)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   always #5 clk = ~clk;

   logic [9:0] obs4;
   logic [9:0] obs3;
   assign obs4 = {bus4.gnt, bus4.gnt_id, bus4.bus_bsy, bus4.to_pulse, bus4.to_id};
   assign obs3 = {1'b0, bus3.gnt, bus3.gnt_id, bus3.bus_bsy, bus3.to_pulse, bus3.to_id};

   function automatic model_t model_reset();
      model_t m;
      m.own = -1; m.ptr = 0; m.held = 0; m.to = 1'b0; m.toid = 0;
      return m;
   endfunction

   // One clock edge of the ownership rules: owner keeps the bus until done/abandon(/timeout);
   // otherwise the first requester at or after ptr (mod n) wins.
   function automatic model_t model_step(model_t m, int n, logic [3:0] r, logic [3:0] d);
      model_t x = m;
      x.to = 1'b0;
      if (m.own >= 0) begin
         x.held = m.held + 1;
         if (d[m.own] || !r[m.own]) begin
            x.own = -1;
            x.ptr = (m.own + 1) % n;
         end
`ifdef RR_ARB_WATCHDOG_EN
         else if (x.held == HOLD_MAX) begin
            x.own  = -1;
            x.ptr  = (m.own + 1) % n;
            x.to   = 1'b1;
            x.toid = m.own;
         end
`endif
      end else begin
         for (int k = 0; k < n; k++) begin
            int c = (m.ptr + k) % n;
            if (x.own < 0 && r[c]) x.own = c;
         end
         x.held = 0;
      end
      return x;
   endfunction

   function automatic logic [9:0] exp_vec(model_t m);
      logic [3:0] g = (m.own >= 0) ? 4'(1 << m.own) : 4'b0000;
      return {g, 2'((m.own >= 0) ? m.own : 0), (m.own >= 0), m.to, 2'(m.toid)};
   endfunction

   task automatic tick();
      @(posedge clk);
      m4 = model_step(m4, 4, bus4.req, bus4.done);
      m3 = model_step(m3, 3, {1'b0, bus3.req}, {1'b0, bus3.done});
      #1;
   endtask

   task automatic apply_reset();
      bus4.req = '0; bus4.done = '0;
      bus3.req = '0; bus3.done = '0;
      rst = 1'b1;
      m4 = model_reset();
      m3 = model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus4.req = '0; bus4.done = '0;
      bus3.req = '0; bus3.done = '0;
      rst = 1'b1;
      m4 = model_reset();
      m3 = model_reset();
      @(posedge clk);
      #1;
      total++;
      if (obs4 !== 10'd0) begin
         bad++;
         $display("FAIL reset_hold: got=%b want=%b", obs4, 10'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (obs4 !== 10'd0 || obs4 !== exp_vec(m4)) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d: got=%b want=%b", i, obs4, 10'd0);
         end
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int cyc = 0;
      int gap = 0;
      bit prev = 1'b0;
      apply_reset();
      bus4.req = 4'b1111;
      for (int i = 0; i < 60 && order.size() < 5; i++) begin
         tick();
         total++;
         if (obs4 !== exp_vec(m4)) begin
            bad++;
            $display("FAIL rr_cycle cyc=%0d: got=%b want=%b", i, obs4, exp_vec(m4));
         end
         if (bus4.bus_bsy) begin
            if (!prev) begin
               if (order.size() > 0) begin
                  total++;
                  if (gap !== 1) begin
                     bad++;
                     $display("FAIL rr_gap: got=%0d want=1", gap);
                  end
               end
               order.push_back(int'(bus4.gnt_id));
               cyc = 1;
            end else begin
               cyc++;
            end
            gap = 0;
         end else begin
            gap++;
         end
         prev = bus4.bus_bsy;
         bus4.done = (cyc == 3 && bus4.bus_bsy) ? bus4.gnt : 4'b0000;
      end
      bus4.done = '0;
      total++;
      if (order.size() !== 5) begin
         bad++;
         $display("FAIL rr_count: got=%0d want=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
               bad++;
               $display("FAIL rr_order idx=%0d: got=%0d want=%0d", i, order[i], exp_order[i]);
            end
         end
      end
   endtask

   task automatic test_ch3_wrap();
      int order[$];
      int exp_order[3] = '{0, 2, 0};
      int cyc = 0;
      apply_reset();
      bus3.req = 3'b101;
      for (int i = 0; i < 30 && order.size() < 3; i++) begin
         tick();
         total++;
         if (obs3 !== exp_vec(m3) || bus3.gnt_id === 2'd3) begin
            bad++;
            $display("FAIL ch3_cycle cyc=%0d: got=%b want=%b", i, obs3, exp_vec(m3));
         end
         if (bus3.bus_bsy) begin
            cyc++;
            if (cyc == 1) order.push_back(int'(bus3.gnt_id));
         end else begin
            cyc = 0;
         end
         bus3.done = (cyc == 2) ? bus3.gnt : 3'b000;
      end
      bus3.done = '0;
      total++;
      if (order.size() !== 3) begin
         bad++;
         $display("FAIL ch3_count: got=%0d want=3", order.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
               bad++;
               $display("FAIL ch3_order idx=%0d: got=%0d want=%0d", i, order[i], exp_order[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) bus4.req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) bus3.req = 3'($urandom);
         bus4.done = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
         bus3.done = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
         tick();
         total++;
         if (obs4 !== exp_vec(m4)) begin
            bad++;
            $display("FAIL rand4 cyc=%0d: got=%b want=%b", i, obs4, exp_vec(m4));
         end
         total++;
         if (obs3 !== exp_vec(m3)) begin
            bad++;
            $display("FAIL rand3 cyc=%0d: got=%b want=%b", i, obs3, exp_vec(m3));
         end
      end
      bus4.req = '0; bus4.done = '0;
      bus3.req = '0; bus3.done = '0;
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      bus4.req = 4'b0100;
      tick();
      total++;
      if (obs4 !== exp_vec(m4) || bus4.gnt !== 4'b0100) begin
         bad++;
         $display("FAIL mid_grant_setup: got=%b want=%b", obs4, exp_vec(m4));
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (bus4.gnt !== 4'b0000 || bus4.bus_bsy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: gnt=%b bsy=%b want gnt=0000 bsy=0", bus4.gnt, bus4.bus_bsy);
      end
      m4 = model_reset();
      m3 = model_reset();
      bus4.req = 4'b0101;
      #2;
      rst = 1'b0;
      tick();
      total++;
      if (obs4 !== exp_vec(m4) || bus4.gnt !== 4'b0001) begin
         bad++;
         $display("FAIL reset_exit_grant: got=%b want gnt=0001", obs4);
      end
      bus4.req = '0;
   endtask

`ifdef RR_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      int hi = 0;
      int pulses = 0;
      int after = -1;
      apply_reset();
      bus4.req = 4'b0110;
      for (int i = 0; i < 40 && after < 0; i++) begin
         tick();
         total++;
         if (obs4 !== exp_vec(m4)) begin
            bad++;
            $display("FAIL wd_cycle cyc=%0d: got=%b want=%b", i, obs4, exp_vec(m4));
         end
         if (bus4.gnt[1]) hi++;
         if (bus4.to_pulse) begin
            pulses++;
            total++;
            if (bus4.to_id !== 2'd1 || hi !== HOLD_MAX) begin
               bad++;
               $display("FAIL wd_expiry: to_id=%0d held=%0d want to_id=1 held=%0d", bus4.to_id, hi, HOLD_MAX);
            end
         end
         if (pulses > 0 && bus4.bus_bsy) after = int'(bus4.gnt_id);
      end
      total++;
      if (pulses !== 1 || after !== 2) begin
         bad++;
         $display("FAIL wd_next: pulses=%0d next=%0d want pulses=1 next=2", pulses, after);
      end
      bus4.req = '0;
   endtask

   task automatic test_wd_done();
      int cyc = 0;
      apply_reset();
      bus4.req = 4'b0010;
      for (int i = 0; i < 30 && cyc < HOLD_MAX; i++) begin
         tick();
         if (bus4.gnt[1]) cyc++;
      end
      bus4.done = 4'b0010;
      tick();
      total++;
      if (obs4 !== exp_vec(m4) || bus4.to_pulse !== 1'b0 || bus4.gnt !== 4'b0000) begin
         bad++;
         $display("FAIL wd_done_precedence: got=%b want=%b", obs4, exp_vec(m4));
      end
      bus4.done = '0;
      bus4.req  = '0;
   endtask
`endif

   initial begin
      bus4.req = '0; bus4.done = '0;
      bus3.req = '0; bus3.done = '0;
      test_reset();
      test_round_robin();
      test_ch3_wrap();
      test_random();
      test_reset_mid_grant();
`ifdef RR_ARB_WATCHDOG_EN
      test_watchdog();
      test_wd_done();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

- Parametrised round-robin arbiter that grants exclusive ownership of the shared bus to one of `N_CH` interface controllers (read/write state machine pairs).
- Successor to the fixed two-party turn-change arbiter. Adds N-channel fairness, a registered one-hot grant, release handshake, a mandatory turnaround cycle and an optional hold-time watchdog.
- Sits between the per-node `bs_rqst` outputs and the bus tri-state enables.

## Interface

Parameters:
- `N_CH`, default 4: number of requesting channels, ≥1, any integer (not restricted to powers of two).
- `HOLD_MAX`, default 16: maximum cycles a grant may be held when the watchdog is compiled in, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_CH  per-channel bus request, level.
- `done`  in  N_CH  per-channel release strobe, sampled only for the granted channel.
- `gnt`  out  N_CH  registered one-hot grant; all-zero when nobody owns the bus.
- `gnt_id`  out  $clog2(N_CH) (min 1)  index of the granted channel; 0 when `gnt` is zero.
- `bus_bsy`  out  1  high while any grant is active.
- `to_pulse`  out  1  one-cycle pulse on a forced (watchdog) release.
- `to_id`  out  $clog2(N_CH) (min 1)  channel released by the watchdog; holds its last value.

## Operation

- FSM states:
  - IDLE: no grant.
  - BUSY: grant held.
  - TURN: one dead cycle after every release.
- Arbitration (IDLE or TURN, any `req` high):
  - Select the first set bit of `req`, searching from `ptr` upward with wrap modulo `N_CH`.
  - Register `gnt`/`gnt_id` for the winner and go to BUSY.
  - With no `req`: TURN→IDLE, IDLE stays IDLE.
- `ptr`:
  - Resets to 0.
  - On every release of channel i, `ptr` ← (i+1) mod `N_CH`. Wrap is correct for non-power-of-two `N_CH`.
- BUSY release conditions, checked each edge for the granted channel i:
  - `done[i]` = 1: normal release.
  - `req[i]` = 0: abandon, treated as a normal release.
  - Watchdog expiry (macro only): forced release, `to_pulse` = 1 for one cycle, `to_id` = i.
  - All three lead to TURN with `gnt` = 0 and `bus_bsy` = 0.
- Precedence when events coincide:
  - `done[i]` or `req[i]` low in the same cycle as expiry → normal release, no `to_pulse`.
- `done` bits of non-granted channels are ignored in every state.
- `hold_cnt` (width $clog2(HOLD_MAX+1)):
  - Cleared on entry to BUSY.
  - Increments each BUSY cycle.
  - Saturates; never wraps.
- Reset values: state IDLE, `gnt` 0, `gnt_id` 0, `bus_bsy` 0, `to_pulse` 0, `to_id` 0, `ptr` 0, `hold_cnt` 0.
- Reset asserted mid-grant drops `gnt` and `bus_bsy` asynchronously. There is no TURN cycle on reset exit.

## Timing

- Grant latency: `req[i]` sampled high at edge k in IDLE → `gnt[i]` visible after edge k (1 cycle).
- Release: `done[i]` sampled at edge m → `gnt` = 0 after edge m.
  - TURN occupies the cycle after edge m.
  - Next grant, if requested, appears after edge m+1.
- The minimum gap of one all-zero `gnt` cycle between any two grants is guaranteed, including consecutive grants to the same channel.
- `gnt`, `gnt_id`, `bus_bsy` and `to_pulse` are all registered, with no combinational path from inputs.
- Watchdog: grant starting after edge g is force-released at edge g+`HOLD_MAX`, so `gnt` stays high for exactly `HOLD_MAX` cycles. `to_pulse` is high for the TURN cycle.
- `N_CH` = 1: grant/release still pass through TURN; `ptr` stays 0.

## Configuration

- `RR_ARB_WATCHDOG_EN` defined:
  - Hold-time watchdog, `hold_cnt` compare and `to_pulse`/`to_id` logic are compiled in.
- `RR_ARB_WATCHDOG_EN` undefined:
  - A grant is held until `done[i]` or `req[i]` low, with no limit.
  - `hold_cnt` is removed.
  - `to_pulse` is tied 0 and `to_id` is tied 0.
  - `HOLD_MAX` is ignored.

## Test plan

- Reset, then `req` = 4'b0000 for 10 cycles → `gnt` = 0, `bus_bsy` = 0, `gnt_id` = 0 throughout.
- `req` = 4'b1111 held, each owner pulses `done` on its 3rd grant cycle → grant order 0,1,2,3,0; exactly one `gnt` = 0 cycle between consecutive grants.
- `N_CH` = 3, `req` = 3'b101, channel 2 released → next grant goes to channel 0 (pointer wraps to 0); `ptr` never reaches 3.
- Watchdog build, `HOLD_MAX` = 16, channel 1 granted with no `done` → `gnt[1]` high for exactly 16 cycles, then `to_pulse` = 1 and `to_id` = 1 for one cycle; next grant goes to channel 2 if requesting.
- Watchdog build, `done[1]` asserted in the expiry cycle → release with `to_pulse` = 0.
- Grant to channel 2 active, `rst` asserted between edges → `gnt` = 0 and `bus_bsy` = 0 immediately; after deassert with `req` = 4'b0101 → channel 0 granted one cycle later.
